// File: rtl/master_trigger_gen.sv
// Radar PRF master trigger source: finite-burst or continuous pulse train with
// programmable period/length, optional start gating on a synchronised external sync edge.
module master_trigger_gen #(
    parameter int PERIOD_W = 32,
    parameter int LENGTH_W = 16,
    parameter int BURST_W  = 16
) (
    input  logic                ipClk,
    input  logic                ipReset,
    input  logic                ipEnable,
    input  logic [PERIOD_W-1:0] ipPeriod,
    input  logic [LENGTH_W-1:0] ipLength,
    input  logic [BURST_W-1:0]  ipBurstCount,
    input  logic                ipUseExtSync,
    input  logic                ipExtSync,
    input  logic                ipStart,
    input  logic                ipAbort,
    output logic                opTrigger,
    output logic                opBusy,
    output logic [BURST_W-1:0]  opPulseCount,
    output logic                opDone
);

    typedef enum logic [1:0] {IDLE, WAIT_SYNC, RUN} state_t;

    state_t              state, state_next;
    logic [PERIOD_W-1:0] period_r, length_r, phase, phase_next;
    logic [BURST_W-1:0]  burst_r;
    logic                sync_p0, sync_p1, sync_p2, sync_edge;
    logic                stop_any, start_ok, last_cycle, done_next;
    logic                load, enter_run, run_step;

    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
        return (p < PERIOD_W'(2)) ? PERIOD_W'(2) : p;
    endfunction

    // Length is kept below the period so every period contains at least one low cycle.
    function automatic logic [PERIOD_W-1:0] clamp_length(input logic [LENGTH_W-1:0] l,
                                                         input logic [PERIOD_W-1:0] p);
        logic [PERIOD_W-1:0] l1;
        l1 = (l == '0) ? PERIOD_W'(1) : PERIOD_W'(l);
        return (l1 > p - PERIOD_W'(1)) ? p - PERIOD_W'(1) : l1;
    endfunction

    function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] c);
        return (&c) ? c : c + BURST_W'(1);
    endfunction

    assign stop_any   = ipAbort | ~ipEnable;
    assign start_ok   = ipStart & ipEnable & ~ipAbort;
    assign phase_next = (phase == period_r - PERIOD_W'(1)) ? '0 : phase + PERIOD_W'(1);
    assign last_cycle = (phase == period_r - PERIOD_W'(1)) && (burst_r != '0)
                        && (opPulseCount == burst_r);
    assign done_next  = (phase_next == period_r - PERIOD_W'(1)) && (burst_r != '0)
                        && (opPulseCount == burst_r);
    assign opBusy     = (state != IDLE);

    // Sync stage: two metastability flops, then a registered rising-edge detect
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            sync_p2   <= 1'b0;
            sync_edge <= 1'b0;
        end else begin
            sync_p0   <= ipExtSync;
            sync_p1   <= sync_p0;
            sync_p2   <= sync_p1;
            sync_edge <= sync_p1 & ~sync_p2;
        end
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        enter_run  = 1'b0;
        run_step   = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    load       = 1'b1;
                    enter_run  = ~ipUseExtSync;
                    state_next = ipUseExtSync ? WAIT_SYNC : RUN;
                end
            end
            WAIT_SYNC: begin
                if (sync_edge) begin
                    enter_run  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_cycle) state_next = IDLE;
                else            run_step   = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        if (stop_any) begin
            state_next = IDLE;
            load       = 1'b0;
            enter_run  = 1'b0;
            run_step   = 1'b0;
        end
    end

    // Configuration is captured only when a start is accepted
    always_ff @(posedge ipClk) begin
        if (load) begin
            period_r <= clamp_period(ipPeriod);
            length_r <= clamp_length(ipLength, clamp_period(ipPeriod));
            burst_r  <= ipBurstCount;
        end
    end

    // Output stage: trigger/count/done registered from the phase about to be entered
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            phase        <= '0;
            opTrigger    <= 1'b0;
            opPulseCount <= '0;
            opDone       <= 1'b0;
        end else begin
            opDone <= 1'b0;
            if (load) opPulseCount <= '0;
            if (enter_run) begin
                phase        <= '0;
                opTrigger    <= 1'b1;
                opPulseCount <= load ? BURST_W'(1) : sat_inc(opPulseCount);
            end else if (run_step) begin
                phase     <= phase_next;
                opTrigger <= (phase_next < length_r);
                opDone    <= done_next;
                if (phase_next == '0) opPulseCount <= sat_inc(opPulseCount);
            end else begin
                opTrigger <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_master_trigger_gen.sv
// Directed bench for master_trigger_gen: per-cycle expectations are queued when inputs
// are driven and compared against the DUT outputs on the following falling edge.
module tb_master_trigger_gen;

    logic        ipClk = 1'b0;
    logic        ipReset = 1'b1;
    logic        ipEnable = 1'b0;
    logic [31:0] ipPeriod = '0;
    logic [15:0] ipLength = '0;
    logic [7:0]  ipBurstCount = '0;
    logic        ipUseExtSync = 1'b0;
    logic        ipExtSync = 1'b0;
    logic        ipStart = 1'b0;
    logic        ipAbort = 1'b0;
    logic        opTrigger, opBusy, opDone;
    logic [7:0]  opPulseCount;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic       trig;
        logic       busy;
        logic       done;
        logic [7:0] cnt;
        string      tag;
        int         k;
    } exp_t;

    exp_t sbq[$];

    master_trigger_gen #(.PERIOD_W(32), .LENGTH_W(16), .BURST_W(8)) dut (
        .ipClk(ipClk), .ipReset(ipReset), .ipEnable(ipEnable), .ipPeriod(ipPeriod),
        .ipLength(ipLength), .ipBurstCount(ipBurstCount), .ipUseExtSync(ipUseExtSync),
        .ipExtSync(ipExtSync), .ipStart(ipStart), .ipAbort(ipAbort),
        .opTrigger(opTrigger), .opBusy(opBusy), .opPulseCount(opPulseCount),
        .opDone(opDone)
    );

    always #5 ipClk = ~ipClk;

    task automatic chk_bit(input string tag, input int k, input string what,
                           input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[%0d] %s: got %0b expected %0b", tag, k, what, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int k, input logic et, input logic eb,
                           input logic ed, input logic [7:0] ec);
        chk_bit(tag, k, "trigger", opTrigger, et);
        chk_bit(tag, k, "busy", opBusy, eb);
        chk_bit(tag, k, "done", opDone, ed);
        vectors++;
        assert (opPulseCount === ec) else begin
            miscompares++;
            $error("FAIL %s[%0d] count: got %0d expected %0d", tag, k, opPulseCount, ec);
        end
    endtask

    task automatic step(input logic et, input logic eb, input logic ed,
                        input logic [7:0] ec, input string tag, input int k);
        exp_t e;
        e.trig = et; e.busy = eb; e.done = ed; e.cnt = ec; e.tag = tag; e.k = k;
        sbq.push_back(e);
        @(posedge ipClk);
        @(negedge ipClk);
        e = sbq.pop_front();
        chk_all(e.tag, e.k, e.trig, e.busy, e.done, e.cnt);
    endtask

    // Expected waveform after an accepted start: cycle k=1 is the first trigger cycle.
    task automatic burst_run(input int p, input int l, input int n, input int cycles,
                             input int poke_k, input string tag);
        int pe, le, j, ph, c;
        logic et, eb, ed;
        pe = (p < 2) ? 2 : p;
        le = (l < 1) ? 1 : l;
        if (le > pe - 1) le = pe - 1;
        for (int k = 1; k <= cycles; k++) begin
            j = (k - 1) / pe;
            ph = (k - 1) % pe;
            if (n != 0 && k > n * pe) begin
                et = 1'b0; eb = 1'b0; ed = 1'b0; c = n;
            end else begin
                et = (ph < le);
                eb = 1'b1;
                ed = (n != 0 && k == n * pe);
                c = (j + 1 > 255) ? 255 : j + 1;
            end
            step(et, eb, ed, 8'(c), tag, k);
            ipStart = 1'b0;
            if (k == poke_k) begin
                ipStart = 1'b1; ipPeriod = 32'd3; ipLength = 16'd1; ipBurstCount = 8'd1;
            end
        end
    endtask

    task automatic start_cfg(input int p, input int l, input int n, input logic ext);
        ipPeriod = 32'(p); ipLength = 16'(l); ipBurstCount = 8'(n);
        ipUseExtSync = ext; ipStart = 1'b1;
    endtask

    initial begin
        #1 ipReset = 1'b0;
        @(negedge ipClk);
        chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 8'd0);
        ipReset = 1'b1;
        ipEnable = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'd0, "idle", 0);

        // P=10 L=3 N=4, with an ignored start and config change during the burst
        start_cfg(10, 3, 4, 1'b0);
        burst_run(10, 3, 4, 43, 5, "burst10");

        // Zero period/length clamp to P=2, L=1
        start_cfg(0, 0, 2, 1'b0);
        burst_run(0, 0, 2, 6, 0, "clamp0");

        // Length above period clamps to P-1
        start_cfg(4, 9, 1, 1'b0);
        burst_run(4, 9, 1, 6, 0, "clamplen");

        // Continuous: 100 pulses, then abort in the first cycle of pulse 101
        start_cfg(5, 2, 0, 1'b0);
        burst_run(5, 2, 0, 501, 0, "cont");
        ipAbort = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'd101, "abort", 0);
        ipAbort = 1'b0;
        step(1'b0, 1'b0, 1'b0, 8'd101, "abort", 1);

        // Continuous saturation of the pulse counter, then disable
        start_cfg(2, 1, 0, 1'b0);
        burst_run(2, 1, 0, 600, 0, "sat");
        ipEnable = 1'b0;
        step(1'b0, 1'b0, 1'b0, 8'd255, "disable", 0);

        // Start with enable low is ignored
        start_cfg(6, 2, 1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'd255, "start_dis", 0);
        ipStart = 1'b0;
        ipEnable = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'd255, "start_dis", 1);

        // Start and abort together: abort wins, count not cleared
        start_cfg(6, 2, 1, 1'b0);
        ipAbort = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'd255, "start_abort", 0);
        ipStart = 1'b0;
        ipAbort = 1'b0;
        step(1'b0, 1'b0, 1'b0, 8'd255, "start_abort", 1);

        // External sync: wait 50 cycles with no edge, then edge -> trigger 4 cycles later
        start_cfg(6, 2, 1, 1'b1);
        for (int k = 1; k <= 51; k++) begin
            step(1'b0, 1'b1, 1'b0, 8'd0, "wait_sync", k);
            ipStart = 1'b0;
        end
        ipExtSync = 1'b1;
        for (int k = 1; k <= 3; k++) step(1'b0, 1'b1, 1'b0, 8'd0, "sync_lat", k);
        burst_run(6, 2, 1, 8, 0, "sync_burst");
        ipExtSync = 1'b0;
        ipUseExtSync = 1'b0;

        // Reset asserted mid-pulse, then a fresh burst
        start_cfg(8, 4, 3, 1'b0);
        burst_run(8, 4, 3, 10, 0, "pre_reset");
        #2 ipReset = 1'b0;
        #1 chk_all("async_reset", 0, 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge ipClk);
        ipReset = 1'b1;
        start_cfg(8, 4, 3, 1'b0);
        burst_run(8, 4, 3, 26, 0, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
